// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Board-level reset manager sitting between the PLL and the design core.
// The raw active-low button and the PLL lock are synchronised, the button is
// debounced, and once the PLL is locked with the button released the resets
// are held for HOLD_CYCLES and then released one bit at a time, bit 0 first,
// STAGGER_CYCLES apart. Losing lock or a debounced button press re-asserts
// every reset output. Lock-loss events are counted (saturating at 255).
//
// Ports
//   clk             : PLL output clock, the only clock
//   rst_n           : asynchronous active-low reset, clears all state
//   btn_n_i         : raw user button, low = pressed, asynchronous
//   pll_lock_i      : PLL lock, high = locked, asynchronous
//   rst_o           : active-high resets, released synchronously, bit 0 first
//   ready_o         : high once every rst_o bit is low
//   lock_loss_cnt_o : number of lock-loss events, saturating at 255
//   dbg_state_o     : sequencer state (0 WAIT_LOCK, 1 HOLD, 2 RELEASE, 3 RUN)
//
// There are no valid/ready handshakes in this block; all outputs are plain
// registered levels.
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int HOLD_CYCLES     = 1024,
  parameter int STAGGER_CYCLES  = 16,
  parameter int NUM_RST         = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_n_i,
  input  logic               pll_lock_i,
  output logic [NUM_RST-1:0] rst_o,
  output logic               ready_o,
  output logic [7:0]         lock_loss_cnt_o,
  output logic [1:0]         dbg_state_o
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SEQ_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

  localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEQ_W-1:0]   HOLD_LAST = SEQ_W'(HOLD_CYCLES - 1);
  localparam logic [SEQ_W-1:0]   STAG_LAST = SEQ_W'(STAGGER_CYCLES - 1);
  localparam logic [NUM_RST-1:0] RST_ALL   = '1;
  // Only the top reset bit still asserted: the next release finishes the run.
  localparam logic [NUM_RST-1:0] RST_MSB   = NUM_RST'(1) << (NUM_RST - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers. The button chain resets to "released", lock to "unlocked".
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic                   w_btn_sync;
  logic                   w_lock_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_sync  <= '1;
      r_lock_sync <= '0;
    end else begin
      r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], btn_n_i};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  assign w_btn_sync  = r_btn_sync[SYNC_STAGES-1];
  assign w_lock_sync = r_lock_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce: a change must persist DEBOUNCE_CYCLES consecutive cycles.
  // ---------------------------------------------------------------------------
  logic            r_btn_db;
  logic [DB_W-1:0] r_db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_db <= 1'b1;
      r_db_cnt <= '0;
    end else if (w_btn_sync != r_btn_db) begin
      if (r_db_cnt == DB_LAST) begin
        r_btn_db <= w_btn_sync;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  logic w_ok;
  assign w_ok = w_lock_sync & r_btn_db;

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEQ_W-1:0]   r_cnt;
  logic [SEQ_W-1:0]   w_cnt_nxt;
  logic [NUM_RST-1:0] r_rst;
  logic [NUM_RST-1:0] w_rst_nxt;
  logic               r_ready;
  logic               w_ready_nxt;
  logic [7:0]         r_llc;
  logic [7:0]         w_llc_nxt;
  logic               w_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT_LOCK;
      r_cnt   <= '0;
      r_rst   <= RST_ALL;
      r_ready <= 1'b0;
      r_llc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst   <= w_rst_nxt;
      r_ready <= w_ready_nxt;
      r_llc   <= w_llc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rst_nxt   = r_rst;
    w_ready_nxt = r_ready;
    w_llc_nxt   = r_llc;
    w_abort     = 1'b0;

    case (r_state)
      ST_WAIT_LOCK: begin
        w_rst_nxt   = RST_ALL;
        w_ready_nxt = 1'b0;
        w_cnt_nxt   = '0;
        if (w_ok) begin
          w_state_nxt = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (!w_ok) begin
          w_abort = 1'b1;
        end else if (r_cnt == HOLD_LAST) begin
          // Bit 0 is released on the same edge that leaves HOLD.
          w_cnt_nxt = '0;
          w_rst_nxt = RST_ALL << 1;
          if (NUM_RST == 1) begin
            w_state_nxt = ST_RUN;
            w_ready_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + SEQ_W'(1);
        end
      end

      ST_RELEASE: begin
        if (!w_ok) begin
          w_abort = 1'b1;
        end else if (r_cnt == STAG_LAST) begin
          // Lower bits are already clear, so shifting left releases the
          // lowest still-asserted bit.
          w_cnt_nxt = '0;
          w_rst_nxt = r_rst << 1;
          if (r_rst == RST_MSB) begin
            w_state_nxt = ST_RUN;
            w_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + SEQ_W'(1);
        end
      end

      ST_RUN: begin
        if (!w_ok) begin
          w_abort = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_WAIT_LOCK;
      end
    endcase

    // Common return path to WAIT_LOCK: every reset asserts together.
    if (w_abort) begin
      w_state_nxt = ST_WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_rst_nxt   = RST_ALL;
      w_ready_nxt = 1'b0;
      if (!w_lock_sync && (r_llc != 8'hFF)) begin
        w_llc_nxt = r_llc + 8'd1;
      end
    end
  end

  assign rst_o           = r_rst;
  assign ready_o         = r_ready;
  assign lock_loss_cnt_o = r_llc;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Drives reset_sequencer with SYNC_STAGES=2, DEBOUNCE_CYCLES=8, HOLD_CYCLES=16,
// STAGGER_CYCLES=4, NUM_RST=3. Inputs change on the falling clock edge and
// outputs are sampled 1 time unit after the rising edge.
//
// The reference model tracks how many consecutive edges the "ok" condition
// has held; reset bit i is released once that run reaches
// 1 + HOLD + i*STAGGER edges, and any edge without "ok" restarts the run.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int HOLD = 16;
  localparam int STAG = 4;
  localparam int NR   = 3;

  localparam int S_WAIT = 0;
  localparam int S_HOLD = 1;
  localparam int S_REL  = 2;
  localparam int S_RUN  = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          btn_n = 1'b1;
  logic          lock  = 1'b1;
  logic [NR-1:0] rst_o;
  logic          ready_o;
  logic [7:0]    llc;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .STAGGER_CYCLES (STAG),
    .NUM_RST        (NR)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_n_i        (btn_n),
    .pll_lock_i     (lock),
    .rst_o          (rst_o),
    .ready_o        (ready_o),
    .lock_loss_cnt_o(llc),
    .dbg_state_o    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  bit m_btn_q[SYNC];
  bit m_lock_q[SYNC];
  bit m_db;
  int m_db_run;
  int m_n;      // consecutive edges at which ok held
  int m_llc;

  function automatic void model_reset();
    for (int i = 0; i < SYNC; i++) begin
      m_btn_q[i]  = 1'b1;
      m_lock_q[i] = 1'b0;
    end
    m_db     = 1'b1;
    m_db_run = 0;
    m_n      = 0;
    m_llc    = 0;
  endfunction

  function automatic void model_edge(input bit b, input bit l);
    bit ls;
    bit bs;
    bit ok;
    ls = m_lock_q[SYNC-1];
    bs = m_btn_q[SYNC-1];
    ok = ls & m_db;
    if (!ok) begin
      if (m_n > 0 && !ls && m_llc < 255) m_llc++;
      m_n = 0;
    end else if (m_n < 1000000) begin
      m_n++;
    end
    // Button accepted after DEB consecutive differing samples.
    if (bs != m_db) begin
      m_db_run++;
      if (m_db_run == DEB) begin
        m_db     = bs;
        m_db_run = 0;
      end
    end else begin
      m_db_run = 0;
    end
    for (int i = SYNC - 1; i > 0; i--) begin
      m_btn_q[i]  = m_btn_q[i-1];
      m_lock_q[i] = m_lock_q[i-1];
    end
    m_btn_q[0]  = b;
    m_lock_q[0] = l;
  endfunction

  function automatic int exp_rst();
    int v = 0;
    for (int i = 0; i < NR; i++)
      if (m_n < 1 + HOLD + i * STAG) v |= (1 << i);
    return v;
  endfunction

  function automatic int exp_ready();
    return (m_n >= 1 + HOLD + (NR - 1) * STAG) ? 1 : 0;
  endfunction

  function automatic int exp_state();
    if (m_n == 0) return S_WAIT;
    if (m_n < 1 + HOLD) return S_HOLD;
    if (m_n < 1 + HOLD + (NR - 1) * STAG) return S_REL;
    return S_RUN;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock edge with the given inputs, then model compare
  // ---------------------------------------------------------------------------
  task automatic step(input bit b, input bit l);
    @(negedge clk);
    btn_n = b;
    lock  = l;
    @(posedge clk);
    model_edge(b, l);
    #1;
    chk("mdl_rst",   int'(rst_o),     exp_rst());
    chk("mdl_ready", int'(ready_o),   exp_ready());
    chk("mdl_llc",   int'(llc),       m_llc);
    chk("mdl_state", int'(dbg_state), exp_state());
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rst",   int'(rst_o),     7);
    chk("arst_ready", int'(ready_o),   0);
    chk("arst_llc",   int'(llc),       0);
    chk("arst_state", int'(dbg_state), S_WAIT);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: apply inputs for ncyc edges, then compare
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         btn;
    bit         lock;
    int         ncyc;
    logic [2:0] rst;
    bit         rdy;
    int         llc;
    int         st;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit b, input bit l, input int n,
                              input logic [2:0] r, input bit rd,
                              input int c, input int s);
    vec_t v;
    v.btn = b; v.lock = l; v.ncyc = n; v.rst = r; v.rdy = rd; v.llc = c; v.st = s;
    tbl.push_back(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Power-up: edges counted from the first rising edge after rst_n release.
    add(1, 1,  2, 3'b111, 0, 0, S_WAIT);
    add(1, 1,  1, 3'b111, 0, 0, S_HOLD);   // edge 3
    add(1, 1, 15, 3'b111, 0, 0, S_HOLD);   // edge 18
    add(1, 1,  1, 3'b110, 0, 0, S_REL);    // edge 19
    add(1, 1,  3, 3'b110, 0, 0, S_REL);    // edge 22
    add(1, 1,  1, 3'b100, 0, 0, S_REL);    // edge 23
    add(1, 1,  3, 3'b100, 0, 0, S_REL);    // edge 26
    add(1, 1,  1, 3'b000, 1, 0, S_RUN);    // edge 27
    add(1, 1, 10, 3'b000, 1, 0, S_RUN);
    // Short button pulse is filtered.
    add(0, 1,  5, 3'b000, 1, 0, S_RUN);
    add(1, 1, 12, 3'b000, 1, 0, S_RUN);
    // Button held: btn_db falls at edge 10, resets at edge 11.
    add(0, 1, 10, 3'b000, 1, 0, S_RUN);
    add(0, 1,  1, 3'b111, 0, 0, S_WAIT);
    add(0, 1, 30, 3'b111, 0, 0, S_WAIT);
    // Release must debounce first: HOLD at edge 11, rst_o[0] at edge 27.
    add(1, 1, 10, 3'b111, 0, 0, S_WAIT);
    add(1, 1,  1, 3'b111, 0, 0, S_HOLD);
    add(1, 1, 15, 3'b111, 0, 0, S_HOLD);
    add(1, 1,  1, 3'b110, 0, 0, S_REL);
    add(1, 1,  8, 3'b000, 1, 0, S_RUN);
    // Lock loss in RUN: resets and count at edge 3, then a full relock.
    add(1, 0,  2, 3'b000, 1, 0, S_RUN);
    add(1, 0,  1, 3'b111, 0, 1, S_WAIT);
    add(1, 0,  5, 3'b111, 0, 1, S_WAIT);
    add(1, 1,  2, 3'b111, 0, 1, S_WAIT);
    add(1, 1,  1, 3'b111, 0, 1, S_HOLD);
    add(1, 1, 15, 3'b111, 0, 1, S_HOLD);
    add(1, 1,  1, 3'b110, 0, 1, S_REL);
    add(1, 1,  8, 3'b000, 1, 1, S_RUN);
    // Abort in HOLD at count 10, then relock with a fresh hold interval.
    add(1, 0,  3, 3'b111, 0, 2, S_WAIT);
    add(1, 0,  2, 3'b111, 0, 2, S_WAIT);
    add(1, 1,  3, 3'b111, 0, 2, S_HOLD);
    add(1, 1,  8, 3'b111, 0, 2, S_HOLD);
    add(1, 0,  2, 3'b111, 0, 2, S_HOLD);
    add(1, 0,  1, 3'b111, 0, 3, S_WAIT);
    add(1, 1,  3, 3'b111, 0, 3, S_HOLD);
    add(1, 1, 15, 3'b111, 0, 3, S_HOLD);
    add(1, 1,  1, 3'b110, 0, 3, S_REL);

    // Reset state check while rst_n is held low.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rst_o",   int'(rst_o),     7);
    chk("rst_ready",   int'(ready_o),   0);
    chk("rst_llc",     int'(llc),       0);
    chk("rst_state",   int'(dbg_state), S_WAIT);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    foreach (tbl[i]) begin
      repeat (tbl[i].ncyc) step(tbl[i].btn, tbl[i].lock);
      chk($sformatf("tbl%0d_rst", i),   int'(rst_o),     int'(tbl[i].rst));
      chk($sformatf("tbl%0d_ready", i), int'(ready_o),   int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_llc", i),   int'(llc),       tbl[i].llc);
      chk($sformatf("tbl%0d_state", i), int'(dbg_state), tbl[i].st);
    end

    // Asynchronous reset between edges while in RELEASE.
    step(1, 1);
    pulse_reset();
    repeat (2) step(1, 1);
    chk("rerun_wait", int'(dbg_state), S_WAIT);
    step(1, 1);
    chk("rerun_hold", int'(dbg_state), S_HOLD);
    repeat (15) step(1, 1);
    chk("rerun_rst_held", int'(rst_o), 7);
    step(1, 1);
    chk("rerun_rst0", int'(rst_o), 6);

    // Saturation: 260 HOLD -> lock-loss round trips.
    for (int k = 0; k < 260; k++) begin
      repeat (3) step(1, 1);
      repeat (3) step(1, 0);
    end
    chk("sat_llc", int'(llc), 255);
    repeat (3) step(1, 1);
    repeat (3) step(1, 0);
    chk("sat_llc_hold", int'(llc), 255);

    // Randomised segments checked against the model on every edge.
    for (int s = 0; s < 60; s++) begin
      bit b;
      bit l;
      int len;
      b   = ($urandom_range(0, 5) != 0);
      l   = ($urandom_range(0, 5) != 0);
      len = $urandom_range(1, 60);
      repeat (len) step(b, l);
      if ($urandom_range(0, 19) == 0) pulse_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised board-level reset manager between the PLL and the design core, replacing the single raw-button reset. Synchronises and debounces the active-low user button, waits for PLL lock, holds reset for a programmable interval, then releases NUM_RST independent active-high reset outputs in a staggered order. Any lock loss or debounced button press re-asserts every reset output. Also keeps a saturating count of lock-loss events.

## Interface
- SYNC_STAGES, 2: synchroniser flops on `btn_n_i` and `pll_lock_i`; range 2..4.
- DEBOUNCE_CYCLES, 65536: consecutive cycles a synchronised button change must persist before it is accepted; at least 1.
- HOLD_CYCLES, 1024: cycles reset is held after lock with the button released; at least 1.
- STAGGER_CYCLES, 16: cycles between successive `rst_o` bit releases; at least 1.
- NUM_RST, 2: number of reset outputs; range 1..8.
- `clk` in 1: PLL output clock; the only clock.
- `rst_n` in 1: asynchronous, active-low; clears all state.
- `btn_n_i` in 1: raw button, low = pressed; asynchronous to `clk`.
- `pll_lock_i` in 1: PLL LOCK, high = locked; asynchronous.
- `rst_o` out NUM_RST: active-high resets, synchronously released; bit 0 released first.
- `ready_o` out 1: high once every `rst_o` bit is low.
- `lock_loss_cnt_o` out 8: lock-loss events, saturating at 255.

## Operation
- **Reset values** while `rst_n` is low:
  - `rst_o` = all ones, `ready_o` = 0, `lock_loss_cnt_o` = 0.
  - State = WAIT_LOCK; all counters = 0.
  - Button synchroniser and debounced value (`btn_db`) = 1. Lock synchroniser = 0.
- **Synchronisers:** SYNC_STAGES-deep flop chains produce `btn_sync` and `lock_sync`.
- **Debounce:**
  - When `btn_sync` equals `btn_db`, the debounce counter clears.
  - When they differ, the counter increments.
  - If they differ and the counter equals DEBOUNCE_CYCLES-1, `btn_db` takes `btn_sync` and the counter clears.
- **`ok` signal:** `ok` = `lock_sync` and `btn_db`.
- **State machine:**
  - WAIT_LOCK: `rst_o` all ones. If `ok`, go to HOLD with the counter cleared.
  - HOLD: the counter increments. If `ok` drops, go to WAIT_LOCK. If the counter equals HOLD_CYCLES-1, go to RELEASE; `rst_o[0]` clears on the same edge and the counter clears.
  - RELEASE: the counter counts to STAGGER_CYCLES-1. At wrap, clear the next `rst_o` bit in index order. When bit NUM_RST-1 clears, go to RUN and set `ready_o` on the same edge. If `ok` drops, go to WAIT_LOCK.
  - RUN: hold the outputs. If `ok` drops, go to WAIT_LOCK.
- **Entering WAIT_LOCK** from HOLD, RELEASE or RUN sets all `rst_o` bits and clears `ready_o` on that edge, simultaneously.
- **Lock-loss counting:** `lock_loss_cnt_o` increments on that transition when `lock_sync` is 0, including when a button press coincides. It saturates at 255.
- **NUM_RST = 1:** the state machine goes directly from HOLD to RUN. `rst_o[0]` clears and `ready_o` sets on the same edge.
- **Button held pressed:** the block stays in WAIT_LOCK indefinitely. Release must debounce before HOLD begins.
- **Widths:** counters are sized by $clog2 of the largest terminal count. Outputs are registered; no combinational input-to-output path.

## Timing
Edge 1 is the first `clk` edge after an input changes.
- **Lock rise** (button already released): `lock_sync` = 1 at edge SYNC_STAGES; HOLD is entered at SYNC_STAGES+1.
- **Reset release:**
  - `rst_o[0]` falls at edge SYNC_STAGES+1+HOLD_CYCLES.
  - `rst_o[i]` falls i·STAGGER_CYCLES edges after `rst_o[0]`.
  - `ready_o` rises with `rst_o[NUM_RST-1]`.
- **Lock fall:** all `rst_o` = 1 at edge SYNC_STAGES+1.
- **Button press:** `btn_db` falls at edge SYNC_STAGES+DEBOUNCE_CYCLES; all `rst_o` = 1 at the next edge.
- **Short pulses:** pulses shorter than DEBOUNCE_CYCLES synchronised cycles have no effect.
- **Asynchronous reset:** `rst_n` low asserts all outputs to their reset values immediately, without a clock edge, from any state.

## Test plan
Parameters for all scenarios: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, HOLD_CYCLES=16, STAGGER_CYCLES=4, NUM_RST=3.
- **Power-up:** `pll_lock_i`=1, `btn_n_i`=1, `rst_n` released before edge 1 → HOLD at edge 3; `rst_o` bits fall at edges 19, 23, 27; `ready_o`=1 at edge 27.
- **Debounce** in RUN:
  - `btn_n_i` low for 5 cycles → no output change.
  - `btn_n_i` held low → `rst_o`=3'b111, `ready_o`=0 at edge 11.
  - After release, the sequence restarts only after the debounced release.
- **Lock loss** in RUN: `pll_lock_i` falls → `rst_o`=3'b111 and `lock_loss_cnt_o`=1 at edge 3. Relock → full sequence repeats with fresh HOLD timing.
- **Abort in HOLD:** lock drops at HOLD count 10 → WAIT_LOCK. On relock, `rst_o[0]` falls exactly 16 cycles after HOLD re-entry, not 6.
- **Async reset in RELEASE:** `rst_n` pulsed low between clock edges after `rst_o[0]` falls → `rst_o`=3'b111, `ready_o`=0, counter=0 immediately. Sequence restarts from WAIT_LOCK.
- **Saturation:** 260 lock-loss cycles → `lock_loss_cnt_o`=255 and stays there.
